// File: rtl/appx_acc_pkg.sv
// Shared types, default widths and overflow detection for the approximate MAC accumulator.
package appx_acc_pkg;

  localparam int PW_DEF = 32;
  localparam int AW_DEF = 40;
  localparam int CW_DEF = 8;

  // Working width for carry detection; accumulator widths must stay below it.
  localparam int OVF_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    HOLD
  } state_t;

  // Carry out of bit w-1 when adding two operands that each fit in w bits.
  function automatic logic add_carry(input logic [OVF_W-1:0] a,
                                     input logic [OVF_W-1:0] b,
                                     input int               w);
    logic [OVF_W-1:0] s;
    s = a + b;
    return |(s >> w);
  endfunction

endpackage

// File: rtl/appx_acc_add.sv
// Combinational AW-bit accumulate adder with carry out.
// Saturates to all-ones on carry when APPX_ACC_SAT_EN is defined, otherwise wraps.
module appx_acc_add
  import appx_acc_pkg::*;
#(
  parameter int PW = PW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic [AW-1:0] acc,
  input  logic [PW-1:0] prod,
  output logic [AW-1:0] sum,
  output logic          carry
);

  logic [AW-1:0] prod_ext;
  logic [AW-1:0] raw;

  assign prod_ext = AW'(prod);
  assign raw      = acc + prod_ext;
  assign carry    = add_carry(OVF_W'(acc), OVF_W'(prod_ext), AW);

`ifdef APPX_ACC_SAT_EN
  // Once clamped, any further carry re-clamps, so the sum stays pinned at all-ones.
  assign sum = carry ? '1 : raw;
`else
  assign sum = raw;
`endif

endmodule

// File: rtl/appx_mac_accum.sv
// Accumulates a programmable number of unsigned products and presents one held result.
// Overflow behaviour (saturate vs wrap) selected by APPX_ACC_SAT_EN in appx_acc_add.
module appx_mac_accum
  import appx_acc_pkg::*;
#(
  parameter int PW = PW_DEF,
  parameter int AW = AW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic [CW-1:0] cfg_len,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_prod,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_acc,
  output logic [CW-1:0] out_count,
  output logic          out_ovf
);

  state_t        state, state_nxt;
  logic          alive;
  logic [AW-1:0] acc;
  logic [AW-1:0] sum;
  logic          carry;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] len;
  logic [CW-1:0] len_first;
  logic          ovf;
  logic          beat;

  assign beat      = in_valid && in_ready;
  assign cnt_inc   = cnt + CW'(1);
  assign len_first = (cfg_len == '0) ? CW'(1) : cfg_len;

  appx_acc_add #(
    .PW(PW),
    .AW(AW)
  ) u_add (
    .acc  (acc),
    .prod (in_prod),
    .sum  (sum),
    .carry(carry)
  );

  // NOTE: flops use non-blocking assignment so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: state_nxt is defaulted first so no branch leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (beat) state_nxt = (len_first == CW'(1)) ? HOLD : ACC;
        ACC:     if (beat && cnt_inc == len) state_nxt = HOLD;
        HOLD:    if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // alive holds in_ready low during reset and releases it on the first edge after.
  always_comb begin
    in_ready  = alive && (state != HOLD);
    out_valid = (state == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive <= 1'b0;
      acc   <= '0;
      cnt   <= '0;
      len   <= '0;
      ovf   <= 1'b0;
    end else begin
      alive <= 1'b1;
      if (clr) begin
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end else if (beat) begin
        if (state == IDLE) begin
          len <= len_first;
          acc <= AW'(in_prod);
          cnt <= CW'(1);
          ovf <= 1'b0;
        end else begin
          acc <= sum;
          cnt <= cnt_inc;
          ovf <= ovf | carry;
        end
      end
    end
  end

  assign out_acc   = acc;
  assign out_count = cnt;
  assign out_ovf   = ovf;

endmodule

// File: tb/tb_appx_mac_accum.sv
// Scoreboard bench for appx_mac_accum: a default-width instance plus an AW=33 instance on shared inputs.
`timescale 1ns/1ps
module tb_appx_mac_accum;

  localparam int PW  = 32;
  localparam int AW  = 40;
  localparam int CW  = 8;
  localparam int AW2 = 33;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           clr = 1'b0;
  logic [CW-1:0]  cfg_len = '0;
  logic           in_valid = 1'b0;
  logic [PW-1:0]  in_prod = '0;
  logic           out_ready = 1'b0;
  logic           in_ready, out_valid, out_ovf;
  logic [AW-1:0]  out_acc;
  logic [CW-1:0]  out_count;
  logic           in_ready2, out_valid2, out_ovf2;
  logic [AW2-1:0] out_acc2;
  logic [CW-1:0]  out_count2;

  always #5 clk = ~clk;

  appx_mac_accum #(.PW(PW), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_count(out_count), .out_ovf(out_ovf)
  );

  appx_mac_accum #(.PW(PW), .AW(AW2), .CW(CW)) dut33 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready2), .in_prod(in_prod),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_acc(out_acc2), .out_count(out_count2), .out_ovf(out_ovf2)
  );

  typedef struct packed {
    logic [AW-1:0]  acc;
    logic [CW-1:0]  cnt;
    logic           ovf;
    logic [AW2-1:0] acc2;
    logic [CW-1:0]  cnt2;
    logic           ovf2;
  } res_t;

  res_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [63:0] m_acc, m_acc2;
  logic        m_ovf, m_ovf2;
  int          m_cnt;

  task automatic model_add(inout logic [63:0] a, inout logic o,
                           input logic [PW-1:0] p, input int w);
    logic [63:0] lim, s;
    lim = 64'd1 << w;
    s   = a + 64'(p);
    if (s >= lim) begin
      o = 1'b1;
`ifdef APPX_ACC_SAT_EN
      a = lim - 64'd1;
`else
      a = s - lim;
`endif
    end else begin
      a = s;
    end
  endtask

  task automatic model_beat(input logic [PW-1:0] p, input bit first);
    if (first) begin
      m_acc  = 64'(p);
      m_acc2 = 64'(p);
      m_ovf  = 1'b0;
      m_ovf2 = 1'b0;
      m_cnt  = 1;
    end else begin
      model_add(m_acc, m_ovf, p, AW);
      model_add(m_acc2, m_ovf2, p, AW2);
      m_cnt++;
    end
  endtask

  // Called on a falling edge; returns on the falling edge after acceptance with in_valid still high.
  task automatic send_beat(input logic [PW-1:0] p, input bit first, input bit last);
    int waited = 0;
    in_valid = 1'b1;
    in_prod  = p;
    while (in_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: in_ready=%b required 1", in_ready);
    end else begin
      @(posedge clk);
      model_beat(p, first);
      @(negedge clk);
      if (last)
        sb_q.push_back('{acc: m_acc[AW-1:0], cnt: CW'(m_cnt), ovf: m_ovf,
                         acc2: m_acc2[AW2-1:0], cnt2: CW'(m_cnt), ovf2: m_ovf2});
    end
  endtask

  task automatic get_result(output res_t obs, output bit ok);
    int waited = 0;
    out_ready = 1'b1;
    while (out_valid !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    ok  = (out_valid === 1'b1);
    obs = '{acc: out_acc, cnt: out_count, ovf: out_ovf,
            acc2: out_acc2, cnt2: out_count2, ovf2: out_ovf2};
    if (ok) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  function automatic res_t pop_exp();
    if (sb_q.size() == 0) return '0;
    return sb_q.pop_front();
  endfunction

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_acc, out_count, out_ovf} !== '0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b vld=%b acc=%h cnt=%h ovf=%b required all 0",
               in_ready, out_valid, out_acc, out_count, out_ovf);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_before_edge: in_ready=%b required 0", in_ready);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    res_t obs, exp;
    bit   ok;
    cfg_len   = 8'd4;
    out_ready = 1'b1;
    send_beat(32'd6, 1'b1, 1'b0);
    cfg_len = 8'd2;
    send_beat(32'd12, 1'b0, 1'b0);
    send_beat(32'd96, 1'b0, 1'b0);
    send_beat(32'd3072, 1'b0, 1'b1);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency: out_valid=%b in_ready=%b required 1/0", out_valid, in_ready);
    end
    get_result(obs, ok);
    exp = pop_exp();
    checks++;
    if (!ok || obs !== exp) begin
      errors++;
      $display("FAIL basic_result: got %h (valid=%0b) required %h", obs, ok, exp);
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_one_cycle_hold: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_len_zero();
    res_t obs, exp;
    bit   ok;
    cfg_len = 8'd0;
    send_beat(32'hFFFF_0000, 1'b1, 1'b1);
    in_valid = 1'b0;
    get_result(obs, ok);
    exp = pop_exp();
    checks++;
    if (!ok || obs !== exp) begin
      errors++;
      $display("FAIL len_zero_result: got %h (valid=%0b) required %h", obs, ok, exp);
    end
  endtask

  task automatic test_hold();
    res_t obs, exp;
    bit   ok;
    cfg_len   = 8'd3;
    out_ready = 1'b0;
    send_beat(32'd1, 1'b1, 1'b0);
    send_beat(32'd2, 1'b0, 1'b0);
    send_beat(32'd3, 1'b0, 1'b1);
    in_prod = 32'd100;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || in_ready2 !== 1'b0 ||
          out_valid2 !== 1'b1 || out_acc !== AW'(6)) begin
        errors++;
        $display("FAIL hold_stall_%0d: vld=%b rdy=%b rdy2=%b vld2=%b acc=%h required 1/0/0/1/6",
                 i, out_valid, in_ready, in_ready2, out_valid2, out_acc);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    get_result(obs, ok);
    exp = pop_exp();
    checks++;
    if (!ok || obs !== exp) begin
      errors++;
      $display("FAIL hold_result: got %h (valid=%0b) required %h", obs, ok, exp);
    end
    cfg_len = 8'd1;
    send_beat(32'd7, 1'b1, 1'b1);
    in_valid = 1'b0;
    get_result(obs, ok);
    exp = pop_exp();
    checks++;
    if (!ok || obs !== exp) begin
      errors++;
      $display("FAIL hold_next_beat: got %h (valid=%0b) required %h", obs, ok, exp);
    end
  endtask

  task automatic test_overflow();
    res_t obs, exp;
    bit   ok;
    cfg_len = 8'd3;
    for (int i = 0; i < 3; i++) send_beat(32'hFFFF_FFFF, i == 0, i == 2);
    in_valid = 1'b0;
    get_result(obs, ok);
    exp = pop_exp();
    checks++;
    if (!ok || obs !== exp) begin
      errors++;
      $display("FAIL overflow_result: got %h (valid=%0b) required %h", obs, ok, exp);
    end
  endtask

  task automatic test_clr();
    res_t obs, exp;
    bit   ok;
    cfg_len = 8'd4;
    send_beat(32'd5, 1'b1, 1'b0);
    send_beat(32'd5, 1'b0, 1'b0);
    in_prod = 32'd5;
    clr     = 1'b1;
    @(negedge clk);
    clr      = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_acc !== '0 || out_count !== '0) begin
      errors++;
      $display("FAIL clr_acc: rdy=%b vld=%b acc=%h cnt=%h required 1/0/0/0",
               in_ready, out_valid, out_acc, out_count);
    end
    for (int i = 0; i < 4; i++) send_beat(32'd1, i == 0, i == 3);
    in_valid = 1'b0;
    get_result(obs, ok);
    exp = pop_exp();
    checks++;
    if (!ok || obs !== exp) begin
      errors++;
      $display("FAIL clr_then_sum: got %h (valid=%0b) required %h", obs, ok, exp);
    end
    out_ready = 1'b0;
    cfg_len   = 8'd1;
    send_beat(32'd9, 1'b1, 1'b1);
    in_valid = 1'b0;
    exp = pop_exp();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_acc !== '0) begin
      errors++;
      $display("FAIL clr_in_hold: vld=%b rdy=%b acc=%h required 0/1/0", out_valid, in_ready, out_acc);
    end
  endtask

  task automatic test_reset_mid();
    res_t obs, exp;
    bit   ok;
    out_ready = 1'b1;
    cfg_len   = 8'd5;
    send_beat(32'd10, 1'b1, 1'b0);
    send_beat(32'd10, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_acc, out_count, out_ovf} !== '0) begin
      errors++;
      $display("FAIL reset_mid_clear: rdy=%b vld=%b acc=%h cnt=%h ovf=%b required all 0",
               in_ready, out_valid, out_acc, out_count, out_ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) send_beat(32'd10, i == 0, i == 4);
    in_valid = 1'b0;
    get_result(obs, ok);
    exp = pop_exp();
    checks++;
    if (!ok || obs !== exp) begin
      errors++;
      $display("FAIL reset_mid_sum: got %h (valid=%0b) required %h", obs, ok, exp);
    end
  endtask

  task automatic test_max_len();
    res_t obs, exp;
    bit   ok;
    cfg_len = 8'd255;
    for (int i = 0; i < 255; i++) begin
      if (i == 254) begin
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
          errors++;
          $display("FAIL max_len_early: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
      end
      send_beat(32'd1, i == 0, i == 254);
    end
    in_valid = 1'b0;
    get_result(obs, ok);
    exp = pop_exp();
    checks++;
    if (!ok || obs !== exp) begin
      errors++;
      $display("FAIL max_len_result: got %h (valid=%0b) required %h", obs, ok, exp);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len_zero();
    test_hold();
    test_overflow();
    test_clr();
    test_reset_mid();
    test_max_len();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
